// File: rtl/ovl_arb_pkg.sv
// Shared encodings, fire-bus bit positions and OVL-style defaults for the
// round-robin grant arbiter.
package ovl_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam int FIRE_2STATE = 0;
    localparam int FIRE_XCHECK = 1;
    localparam int FIRE_COVER  = 2;

    localparam int OVL_ASSERT = 0;
    localparam int OVL_IGNORE = 4;
    localparam int OVL_ERROR  = 1;

    localparam int    OVL_SEVERITY_DEFAULT = OVL_ERROR;
    localparam int    OVL_PROPERTY_DEFAULT = OVL_ASSERT;
    localparam string OVL_MSG_DEFAULT      = "VIOLATION";
    localparam int    OVL_COVER_DEFAULT    = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ovl_rr_pick.sv
// Rotating-priority search: first set request at or above ptr, wrapping to 0.
module ovl_rr_pick #(
    parameter int width = 4,
    parameter int idw   = 2
) (
    input  logic [width-1:0] req,
    input  logic [idw-1:0]   ptr,
    output logic [width-1:0] winner,
    output logic [idw-1:0]   winner_id,
    output logic             found
);

    int idx;

    always_comb begin
        winner    = '0;
        winner_id = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < width; k++) begin
            idx = int'(ptr) + k;
            if (idx >= width) idx = idx - width;
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_id   = idw'(idx);
            end
        end
    end

endmodule

// File: rtl/ovl_rr_grant_arbiter.sv
// Round-robin arbiter with registered zero-one-hot grant, tenure timeout and
// an OVL-style fire bus for protocol violations and grant coverage.
module ovl_rr_grant_arbiter
    import ovl_arb_pkg::*;
#(
    parameter int    severity_level = OVL_SEVERITY_DEFAULT,
    parameter int    width          = 4,
    parameter int    hold_max       = 16,
    parameter int    property_type  = OVL_PROPERTY_DEFAULT,
    parameter string msg            = OVL_MSG_DEFAULT,
    parameter int    coverage_level = OVL_COVER_DEFAULT,
    localparam int   IDW            = (clog2(width) < 1) ? 1 : clog2(width)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] req,
    input  logic [width-1:0] done,
    output logic [width-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDW-1:0]   gnt_id,
    output logic [2:0]       fire
);

    localparam int HCW = (clog2(hold_max + 1) < 1) ? 1 : clog2(hold_max + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((hold_max == 0) ? 0 : hold_max - 1);
    // An ignored property reports nothing; severity and message only matter off-chip.
    localparam bit REPORT_EN = (property_type != OVL_IGNORE) && (severity_level >= 0) && (msg != "");
    localparam bit COVER_EN  = (coverage_level != 0);

    arb_state_e       state;
    logic [IDW-1:0]   ptr;
    logic [HCW-1:0]   hold_cnt;

    logic [width-1:0] pick_gnt;
    logic [IDW-1:0]   pick_id;
    logic             pick_found;

    logic own_done, own_req, stray, timeout, release_now, timeout_evt, grant_now, xchk;
    logic [IDW-1:0] next_ptr;

    ovl_rr_pick #(
        .width (width),
        .idw   (IDW)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .winner    (pick_gnt),
        .winner_id (pick_id),
        .found     (pick_found)
    );

    // gnt is zero in IDLE, so done & ~gnt covers stray bits in both states.
    always_comb begin
        own_done    = |(done & gnt);
        own_req     = |(req & gnt);
        stray       = |(done & ~gnt);
        timeout     = (hold_max != 0) && (hold_cnt == HOLD_LAST);
        release_now = (state == ST_OWN) && (own_done || !own_req || timeout);
        timeout_evt = (state == ST_OWN) && own_req && !own_done && timeout;
        grant_now   = (state == ST_IDLE) && enable && pick_found;
        next_ptr    = (gnt_id == IDW'(width - 1)) ? '0 : gnt_id + 1'b1;
    end

`ifdef OVL_XCHECK_OFF
    assign xchk = 1'b0;
`else
    assign xchk = REPORT_EN && (enable === 1'b1) && $isunknown({req, done});
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            fire      <= '0;
        end else begin
            fire[FIRE_2STATE] <= REPORT_EN && (stray || timeout_evt);
            fire[FIRE_XCHECK] <= xchk;
            fire[FIRE_COVER]  <= COVER_EN && grant_now;
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        state     <= ST_OWN;
                        gnt       <= pick_gnt;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                ST_OWN: begin
                    if (release_now) begin
                        state     <= ST_IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= next_ptr;
                    end else if (hold_cnt != '1) begin
                        hold_cnt  <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
